// File: rtl/controller_sysid_reader_pkg.sv
// Shared types and constants for the system-ID / timestamp reader.
package controller_sysid_reader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/controller_sysid_reader_timer.sv
// Per-attempt cycle counter plus retry counter for one word read.
module controller_sysid_reader_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic retry_clear,
    input  logic retry_inc,
    output logic expire,
    output logic retry_exhausted
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0] TERM_CNT  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    logic [CW-1:0] cycle_cnt;
    logic [RW-1:0] retry_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cycle_cnt <= '0;
        else if (clear)
            cycle_cnt <= '0;
        else if (enable)
            cycle_cnt <= cycle_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            retry_cnt <= '0;
        else if (retry_clear)
            retry_cnt <= '0;
        else if (retry_inc)
            retry_cnt <= retry_cnt + 1'b1;
    end

    assign expire          = enable && (cycle_cnt == TERM_CNT);
    assign retry_exhausted = (retry_cnt >= RETRY_MAX);

endmodule

// File: rtl/controller_sysid_reader.sv
// Reads the ID and timestamp words over Avalon-MM and compares them against
// the expected build values, with per-word timeout and retry.
//
// state   | meaning
// IDLE    | waiting for start
// ID_REQ  | read request for word 0 (ID) held until accepted
// ID_WAIT | ID request accepted, waiting for readdatavalid
// TS_REQ  | read request for word 1 (timestamp) held until accepted
// TS_WAIT | timestamp request accepted, waiting for readdatavalid
// FINISH  | one-cycle done pulse
module controller_sysid_reader
    import controller_sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd49153,
    parameter logic [31:0] EXPECTED_TS    = 32'd1532492830,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t state, state_nxt;

    logic timer_clear, timer_en, retry_clear, retry_inc;
    logic expire, retry_exhausted;
    logic start_acc, id_capture, ts_capture, attempt_fail, give_up;

    controller_sysid_reader_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timer (
        .clock           (clock),
        .reset           (reset),
        .clear           (timer_clear),
        .enable          (timer_en),
        .retry_clear     (retry_clear),
        .retry_inc       (retry_inc),
        .expire          (expire),
        .retry_exhausted (retry_exhausted)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Data beats a simultaneous timeout; timeout beats a same-cycle accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ID_REQ;
            ID_REQ:  if (expire) state_nxt = retry_exhausted ? FINISH : ID_REQ;
                     else if (!avm_waitrequest) state_nxt = ID_WAIT;
            ID_WAIT: if (avm_readdatavalid) state_nxt = TS_REQ;
                     else if (expire) state_nxt = retry_exhausted ? FINISH : ID_REQ;
            TS_REQ:  if (expire) state_nxt = retry_exhausted ? FINISH : TS_REQ;
                     else if (!avm_waitrequest) state_nxt = TS_WAIT;
            TS_WAIT: if (avm_readdatavalid) state_nxt = FINISH;
                     else if (expire) state_nxt = retry_exhausted ? FINISH : TS_REQ;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        avm_read     = 1'b0;
        avm_address  = ADDR_ID;
        busy         = (state != IDLE);
        done         = (state == FINISH);
        timer_en     = (state == ID_REQ) || (state == ID_WAIT) ||
                       (state == TS_REQ) || (state == TS_WAIT);
        start_acc    = (state == IDLE) && start;
        id_capture   = (state == ID_WAIT) && avm_readdatavalid;
        ts_capture   = (state == TS_WAIT) && avm_readdatavalid;
        attempt_fail = expire && !id_capture && !ts_capture;
        retry_inc    = attempt_fail && !retry_exhausted;
        give_up      = attempt_fail && retry_exhausted;
        retry_clear  = start_acc || id_capture;
        timer_clear  = start_acc || id_capture || retry_inc;
        if (state == ID_REQ) begin
            avm_read    = 1'b1;
            avm_address = ADDR_ID;
        end else if (state == TS_REQ) begin
            avm_read    = 1'b1;
            avm_address = ADDR_TS;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || start_acc) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            if (id_capture) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (ts_capture) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
            if (give_up)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controller_sysid_reader.sv
// Scoreboard bench for controller_sysid_reader: directed sequences against a
// configurable slave model, plus a short-timeout instance with a dead slave.
module tb_controller_sysid_reader;

    localparam logic [31:0] ID_GOOD = 32'd49153;
    localparam logic [31:0] TS_GOOD = 32'd1532492830;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    logic        start_to;
    logic        to_address, to_read, to_busy, to_done, to_id_ok, to_ts_ok, to_timeout_err;
    logic [31:0] to_id_value, to_ts_value;

    always #5 clock = ~clock;

    controller_sysid_reader dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout_err       (timeout_err),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    controller_sysid_reader #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1)) dut_to (
        .clock             (clock),
        .reset             (reset),
        .start             (start_to),
        .avm_address       (to_address),
        .avm_read          (to_read),
        .avm_waitrequest   (1'b0),
        .avm_readdatavalid (1'b0),
        .avm_readdata      (32'd0),
        .busy              (to_busy),
        .done              (to_done),
        .id_ok             (to_id_ok),
        .ts_ok             (to_ts_ok),
        .timeout_err       (to_timeout_err),
        .id_value          (to_id_value),
        .ts_value          (to_ts_value)
    );

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        timeout_err;
        logic [31:0] id_value;
        logic [31:0] ts_value;
        int          latency;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cyc   = 0;

    int          wait_cycles = 0;
    int          lat         = 1;
    logic [31:0] id_data     = ID_GOOD;
    logic [31:0] ts_data     = TS_GOOD;
    int          ws_cnt      = 0;
    int          pend        = 0;
    bit          pend_active = 1'b0;
    logic        pend_addr   = 1'b0;
    bit          in_stall    = 1'b0;
    logic        hold_addr   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic i_ok, input logic t_ok, input logic t_err,
                                    input logic [31:0] iv, input logic [31:0] tv, input int l);
        exp_t e;
        e.id_ok       = i_ok;
        e.ts_ok       = t_ok;
        e.timeout_err = t_err;
        e.id_value    = iv;
        e.ts_value    = tv;
        e.latency     = l;
        return e;
    endfunction

    // Slave model: programmable waitrequest stall and read latency.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clock);
            avm_readdatavalid = 1'b0;
            if (pend_active) begin
                pend--;
                if (pend == 0) begin
                    pend_active       = 1'b0;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_addr ? ts_data : id_data;
                end
            end
            if (reset) begin
                ws_cnt          = 0;
                in_stall        = 1'b0;
                avm_waitrequest = 1'b0;
            end else if (avm_read) begin
                if (in_stall)
                    check1("stall_addr_stable", avm_address, hold_addr);
                if (ws_cnt < wait_cycles) begin
                    avm_waitrequest = 1'b1;
                    ws_cnt++;
                    if (!in_stall) begin
                        in_stall  = 1'b1;
                        hold_addr = avm_address;
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                    ws_cnt          = 0;
                    in_stall        = 1'b0;
                    pend_active     = 1'b1;
                    pend            = lat;
                    pend_addr       = avm_address;
                end
            end else begin
                if (in_stall)
                    check1("stall_read_held", avm_read, 1'b1);
                in_stall        = 1'b0;
                ws_cnt          = 0;
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: every done pulse must match the oldest expected sequence.
    initial begin
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1, expected no sequence pending");
                end else begin
                    mon_e = sb_q.pop_front();
                    check32("done_latency", 32'(cyc - start_cyc + 1), 32'(mon_e.latency));
                    check1("id_ok", id_ok, mon_e.id_ok);
                    check1("ts_ok", ts_ok, mon_e.ts_ok);
                    check1("timeout_err", timeout_err, mon_e.timeout_err);
                    check32("id_value", id_value, mon_e.id_value);
                    check32("ts_value", ts_value, mon_e.ts_value);
                    check1("busy_at_done", busy, 1'b1);
                end
            end
        end
    end

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_no_done: got no done within %0d cycles, expected a done pulse", name, budget);
            sb_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic run_seq(input string name, input logic [31:0] idd, input logic [31:0] tsd,
                           input int ws, input int lt, input exp_t e);
        id_data     = idd;
        ts_data     = tsd;
        wait_cycles = ws;
        lat         = lt;
        @(negedge clock);
        start     = 1'b1;
        start_cyc = cyc;
        sb_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
        wait_done(200, name);
    endtask

    task automatic check_all_zero(input string name);
        check1({name, "_avm_read"}, avm_read, 1'b0);
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_done"}, done, 1'b0);
        check1({name, "_id_ok"}, id_ok, 1'b0);
        check1({name, "_ts_ok"}, ts_ok, 1'b0);
        check1({name, "_timeout_err"}, timeout_err, 1'b0);
        check32({name, "_id_value"}, id_value, 32'd0);
        check32({name, "_ts_value"}, ts_value, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int id_reads;
        int ts_reads;
        bit seen;
        reset    = 1'b1;
        start    = 1'b0;
        start_to = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Nominal, zero-wait slave with 1-cycle latency.
        run_seq("nominal", ID_GOOD, TS_GOOD, 0, 1, mk_exp(1, 1, 0, ID_GOOD, TS_GOOD, 6));
        repeat (3) @(negedge clock);
        check32("hold_id_value", id_value, ID_GOOD);
        check1("hold_id_ok", id_ok, 1'b1);
        check1("hold_busy", busy, 1'b0);

        // ID mismatch.
        run_seq("mismatch", 32'd49152, TS_GOOD, 0, 1, mk_exp(0, 1, 0, 32'd49152, TS_GOOD, 6));

        // Timestamp mismatch.
        run_seq("ts_mismatch", ID_GOOD, 32'd7, 0, 1, mk_exp(1, 0, 0, ID_GOOD, 32'd7, 6));

        // Ten-cycle waitrequest stall on each read.
        run_seq("stall10", ID_GOOD, TS_GOOD, 10, 1, mk_exp(1, 1, 0, ID_GOOD, TS_GOOD, 26));

        // Start pulsed again while busy must be ignored.
        id_data = ID_GOOD; ts_data = TS_GOOD; wait_cycles = 0; lat = 1;
        @(negedge clock);
        start     = 1'b1;
        start_cyc = cyc;
        sb_q.push_back(mk_exp(1, 1, 0, ID_GOOD, TS_GOOD, 6));
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(50, "restart");
        repeat (8) @(negedge clock);

        // Reset in TS_WAIT with a late response afterwards.
        lat = 5;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(avm_read === 1'b1 && avm_address === 1'b1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check1("reset_test_reached_ts_req", avm_read & avm_address, 1'b1);
        repeat (2) @(negedge clock);
        check32("pre_reset_id_value", id_value, ID_GOOD);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_all_zero("post_reset");
        lat = 1;
        run_seq("after_reset", ID_GOOD, TS_GOOD, 0, 1, mk_exp(1, 1, 0, ID_GOOD, TS_GOOD, 6));

        // Dead slave on the short-timeout instance.
        id_reads = 0;
        ts_reads = 0;
        seen     = 1'b0;
        @(negedge clock);
        start_to  = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start_to = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (to_read === 1'b1 && to_address === 1'b0) id_reads++;
            if (to_read === 1'b1 && to_address === 1'b1) ts_reads++;
            if (to_done === 1'b1) begin
                seen = 1'b1;
                check32("dead_latency", 32'(cyc - start_cyc + 1), 32'd10);
                check1("dead_timeout_err", to_timeout_err, 1'b1);
                check1("dead_id_ok", to_id_ok, 1'b0);
                check1("dead_ts_ok", to_ts_ok, 1'b0);
                break;
            end
            @(negedge clock);
        end
        check1("dead_done_seen", seen, 1'b1);
        check32("dead_id_attempts", 32'(id_reads), 32'd2);
        check32("dead_ts_reads", 32'(ts_reads), 32'd0);
        @(negedge clock);
        check1("dead_idle_after", to_busy, 1'b0);

        repeat (4) @(negedge clock);
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controller_sysid_reader.md
CONTROLLER_SYSID_READER -- requirements
Module: controller_sysid_reader

Interface
REQ-001 Parameter EXPECTED_ID, default 49153, system ID value the design must present at slave word 0.
REQ-002 Parameter EXPECTED_TS, default 1532492830, timestamp value the design must present at slave word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max cycles per read attempt from request assertion to data.
REQ-004 Parameter MAX_RETRIES, default 3, re-attempts per word after the first timeout.
REQ-005 clock  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a check sequence when idle.
REQ-008 avm_address  out  1  word select: 0 = ID, 1 = timestamp.
REQ-009 avm_read  out  1  Avalon-MM read request.
REQ-010 avm_waitrequest  in  1  slave stall; request is held while high.
REQ-011 avm_readdatavalid  in  1  read data qualifier.
REQ-012 avm_readdata  in  32  read data.
REQ-013 busy  out  1  high from the cycle after an accepted start until done.
REQ-014 done  out  1  one-cycle pulse at sequence end.
REQ-015 id_ok, ts_ok  out  1 each  captured word equals its expected parameter.
REQ-016 timeout_err  out  1  a word exhausted all retries.
REQ-017 id_value, ts_value  out  32 each  last captured words.

Function
REQ-018 The FSM SHALL have the states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT and FINISH.
REQ-019 In IDLE, start=1 SHALL move to ID_REQ, clear id_ok, ts_ok, timeout_err, id_value and ts_value, and zero the retry count; start outside IDLE SHALL be ignored.
REQ-020 In ID_REQ and TS_REQ, avm_read=1 SHALL be driven with avm_address 0 or 1 respectively; in all other states avm_read=0 and avm_address=0.
REQ-021 A request SHALL be accepted in the cycle where avm_read=1 and avm_waitrequest=0; the FSM SHALL move to the matching *_WAIT state in the next cycle, with address and read stable until acceptance.
REQ-022 Only one read SHALL be outstanding at a time.
REQ-023 avm_readdatavalid SHALL be sampled only in the *_WAIT states; in any other state it SHALL be ignored, so late responses are dropped.
REQ-024 In ID_WAIT, valid data SHALL be captured into id_value and id_ok SHALL be set to (data==EXPECTED_ID), then the FSM SHALL move to TS_REQ and zero the retry count.
REQ-025 In TS_WAIT, valid data SHALL be captured into ts_value and ts_ok SHALL be set to (data==EXPECTED_TS), then the FSM SHALL move to FINISH.
REQ-026 A per-attempt counter SHALL clear on entry to each *_REQ state and increment every cycle in *_REQ and *_WAIT.
REQ-027 When that counter reaches TIMEOUT_CYCLES-1 without data, the attempt SHALL end: if retries < MAX_RETRIES, increment retries and re-enter the same *_REQ; otherwise set timeout_err and go to FINISH, skipping the timestamp read if the ID word failed.
REQ-028 If data is valid in the same cycle the timeout fires, the data SHALL take priority.
REQ-029 FINISH SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 Status and value outputs SHALL hold until the next accepted start.
REQ-031 Minimum latency SHALL be 6 cycles from start to done with zero-wait, 1-cycle readdatavalid slave: start, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.

Reset
REQ-032 reset=1 SHALL force IDLE and drive avm_read, busy, done, id_ok, ts_ok, timeout_err=0 and id_value, ts_value=0 with counters zeroed; reset mid-transaction SHALL abandon the read immediately.

Structure
REQ-033 The state enumeration and the word-address constants (ID=0, TS=1) SHALL live in a shared controller package.
REQ-034 The timeout/retry counter pair SHALL be one sub-module, controller_sysid_reader_timer, with clear, enable, expire and retry-exhausted outputs.

Verification
REQ-035 Nominal: slave returns 49153 then 1532492830 with 1-cycle latency -> done at cycle 6, id_ok=1, ts_ok=1, timeout_err=0.
REQ-036 Mismatch: slave returns 49152 for ID -> id_ok=0, id_value=49152, ts_ok=1, done=1.
REQ-037 Waitrequest held 10 cycles on each read -> avm_read and avm_address stable throughout, values correct, done at cycle 26.
REQ-038 Dead slave with TIMEOUT_CYCLES=4, MAX_RETRIES=1 -> two ID attempts, no TS read, timeout_err=1, done after 8 busy cycles.
REQ-039 Reset asserted in TS_WAIT, then late readdatavalid -> all outputs zero, data ignored, next start runs normally.
REQ-040 start pulsed while busy -> no restart, single done pulse.
